// File: rtl/scan_pkg.sv
// Shared types for the serial 10110 scan controller and its detector core.
package scan_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CNTW  = 5;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    DRAIN  = 2'b10,
    REPORT = 2'b11
  } scan_state_e;

  // Detector states; Sn means the last n bits matched the first n bits of 10110.
  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100,
    S5 = 3'b101
  } det_state_e;

endpackage

// File: rtl/seq10110_core.sv
// Moore detector for serial pattern 10110, overlapping matches allowed.
module seq10110_core
  import scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic j,
  output logic w
);

  det_state_e ps;
  det_state_e ps_nxt;

  // Next state: clear wins, en=0 holds the current state.
  always_comb begin
    ps_nxt = ps;
    if (clr) begin
      ps_nxt = S0;
    end else if (en) begin
      case (ps)
        S0:      ps_nxt = j ? S1 : S0;
        S1:      ps_nxt = j ? S1 : S2;
        S2:      ps_nxt = j ? S3 : S0;
        S3:      ps_nxt = j ? S4 : S2;
        S4:      ps_nxt = j ? S1 : S5;
        S5:      ps_nxt = j ? S3 : S0;
        default: ps_nxt = S0;
      endcase
    end
  end

  // State register; w is registered alongside so it always equals (ps == S5).
  always_ff @(posedge clk) begin
    if (!rst) begin
      ps <= S0;
      w  <= 1'b0;
    end else begin
      ps <= ps_nxt;
      w  <= (ps_nxt == S5);
    end
  end

endmodule

// File: rtl/serial_scan_ctrl.sv
// Accepts a word, shifts it MSB-first through the 10110 detector, returns the hit count.
module serial_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNTW  = DEF_CNTW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [CNTW-1:0]  out_count,
  input  logic             out_ready
);

  localparam int unsigned BCW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  scan_state_e      state;
  scan_state_e      state_nxt;
  logic             load;
  logic             shift_en;
  logic             count_en;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bitcnt;
  logic [CNTW-1:0]  hit_cnt;
  logic [CNTW-1:0]  hit_nxt;
  logic             core_w;

  // Detector core; cleared on every accept so matches never span words.
  seq10110_core u_core (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .en  (shift_en),
    .j   (shreg[WIDTH-1]),
    .w   (core_w)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    count_en  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        count_en = 1'b1;
        if (bitcnt == BCW'(WIDTH - 1)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        count_en  = 1'b1;
        state_nxt = REPORT;
      end
      REPORT: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating hit count; w lags the core by one cycle, so DRAIN picks up the last bit.
  always_comb begin
    hit_nxt = hit_cnt;
    if (load) begin
      hit_nxt = '0;
    end else if (count_en && core_w && (hit_cnt != CNT_MAX)) begin
      hit_nxt = hit_cnt + CNTW'(1);
    end
  end

  // Shift register, bit counter, hit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg     <= '0;
      bitcnt    <= '0;
      hit_cnt   <= '0;
      out_count <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if (load) begin
        shreg  <= in_data;
        bitcnt <= '0;
      end else if (shift_en) begin
        shreg  <= {shreg[WIDTH-2:0], 1'b0};
        bitcnt <= bitcnt + BCW'(1);
      end
      hit_cnt <= hit_nxt;
      if (state == DRAIN) begin
        out_count <= hit_nxt;
      end
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == REPORT);
    end
  end

endmodule

// File: tb/tb_serial_scan_ctrl.sv
// Self-checking bench for serial_scan_ctrl against a pattern-counting reference.
module tb_serial_scan_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNTW  = 5;
  // Accept edge t to first sample with out_valid=1 (just before edge t+WIDTH+2).
  localparam int LAT_EXP = WIDTH + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [CNTW-1:0]  out_count;
  logic             out_ready;

  int errors = 0;
  int checks = 0;

  serial_scan_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_count (out_count),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: slide a 5-bit window across the word and count 10110 windows.
  function automatic int ref_hits(input logic [WIDTH-1:0] word);
    int n = 0;
    logic [WIDTH-1:0] win;
    for (int i = 0; i <= int'(WIDTH) - 5; i++) begin
      win = (word >> i) & WIDTH'(5'h1F);
      if (win == WIDTH'(5'b10110)) n++;
    end
    if (n > (1 << CNTW) - 1) n = (1 << CNTW) - 1;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one word; report wait, latency (-2 no accept, -1 no result), count and any in_ready while busy.
  task automatic run_word(input logic [WIDTH-1:0] word, output int wait_cyc, output int lat,
                          output logic [CNTW-1:0] cnt, output bit ready_leak);
    wait_cyc   = 0;
    lat        = -2;
    cnt        = '0;
    ready_leak = 1'b0;
    while (!in_ready && wait_cyc < 60) begin
      tick();
      wait_cyc++;
    end
    if (!in_ready) return;
    in_valid = 1'b1;
    in_data  = word;
    tick();
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_leak = 1'b1;
      tick();
      lat++;
    end
    if (!out_valid) begin
      lat = -1;
      return;
    end
    cnt = out_count;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_count !== '0) begin errors++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
  endtask

  // Scan one word with out_ready held high, check latency, count and handshake return to IDLE.
  task automatic test_word(input string name, input logic [WIDTH-1:0] word);
    int wc, lat;
    logic [CNTW-1:0] cnt;
    bit leak;
    out_ready = 1'b1;
    run_word(word, wc, lat, cnt, leak);
    checks++;
    if (lat !== LAT_EXP) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, LAT_EXP); end
    checks++;
    if (cnt !== CNTW'(ref_hits(word))) begin errors++; $display("FAIL %s_count word=%h got=%0d exp=%0d", name, word, cnt, ref_hits(word)); end
    checks++;
    if (leak !== 1'b0) begin errors++; $display("FAIL %s_busy_in_ready got=1 exp=0", name); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_handshake out_valid=%b in_ready=%b exp 0/1", name, out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  // Fixed-pattern expectations straight from the pattern rules.
  task automatic test_known_counts();
    int wc, lat;
    logic [CNTW-1:0] cnt;
    bit leak;
    logic [WIDTH-1:0] words [5] = '{16'hB000, 16'hB6C0, 16'h000B, 16'h6000, 16'hFFFF};
    int exp_cnt [5] = '{1, 3, 0, 0, 0};
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run_word(words[k], wc, lat, cnt, leak);
      checks++;
      if (cnt !== CNTW'(exp_cnt[k])) begin
        errors++; $display("FAIL known_count word=%h got=%0d exp=%0d", words[k], cnt, exp_cnt[k]);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  // Word presented right after a handshake is accepted with no extra bubble.
  task automatic test_back_to_back();
    int wc, lat;
    logic [CNTW-1:0] cnt;
    bit leak;
    out_ready = 1'b1;
    run_word(16'h000B, wc, lat, cnt, leak);
    tick();
    run_word(16'h6000, wc, lat, cnt, leak);
    checks++;
    if (wc !== 0) begin errors++; $display("FAIL b2b_wait got=%0d exp=0", wc); end
    checks++;
    if (lat + 2 !== int'(WIDTH) + 3) begin errors++; $display("FAIL b2b_period got=%0d exp=%0d", lat + 2, WIDTH + 3); end
    checks++;
    if (cnt !== '0) begin errors++; $display("FAIL b2b_cross_word got=%0d exp=0", cnt); end
    tick();
    out_ready = 1'b0;
  endtask

  // Hold the result for 5 cycles with in_valid asserted; it must not move.
  task automatic test_backpressure();
    int wc, lat;
    logic [CNTW-1:0] cnt;
    bit leak;
    out_ready = 1'b0;
    run_word(16'hB6C0, wc, lat, cnt, leak);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'($urandom);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_count !== 5'd3 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d out_valid=%b out_count=%0d in_ready=%b exp 1/3/0", k, out_valid, out_count, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  // Reset during bit 8 aborts the scan; the next word scans normally.
  task automatic test_reset_mid();
    int wc, lat;
    logic [CNTW-1:0] cnt;
    bit leak;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hB6C0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== '0) begin
      errors++; $display("FAIL mid_reset in_ready=%b out_valid=%b out_count=%0d exp 1/0/0", in_ready, out_valid, out_count);
    end
    out_ready = 1'b1;
    run_word(16'hB000, wc, lat, cnt, leak);
    checks++;
    if (cnt !== 5'd1 || lat !== LAT_EXP) begin
      errors++; $display("FAIL mid_reset_rescan count=%0d lat=%0d exp 1/%0d", cnt, lat, LAT_EXP);
    end
    tick();
    out_ready = 1'b0;
  endtask

  // Random words, biased toward containing 10110, with random result delay.
  task automatic test_random();
    int wc, lat, dly;
    logic [CNTW-1:0] cnt;
    bit leak;
    logic [WIDTH-1:0] word;
    for (int n = 0; n < 40; n++) begin
      word = WIDTH'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        word[$urandom_range(WIDTH - 1, 4) -: 5] = 5'b10110;
      end
      out_ready = 1'b0;
      run_word(word, wc, lat, cnt, leak);
      checks++;
      if (lat !== LAT_EXP || cnt !== CNTW'(ref_hits(word)) || leak !== 1'b0) begin
        errors++;
        $display("FAIL rand_word word=%h count=%0d exp=%0d lat=%0d exp=%0d leak=%b", word, cnt, ref_hits(word), lat, LAT_EXP, leak);
      end
      dly = $urandom_range(3, 0);
      for (int k = 0; k < dly; k++) tick();
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_count !== cnt) begin
        errors++; $display("FAIL rand_hold out_valid=%b out_count=%0d exp 1/%0d", out_valid, out_count, cnt);
      end
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < int'($urandom_range(2, 0)); k++) tick();
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_word("single", 16'hB000);
    test_word("overlap", 16'hB6C0);
    test_word("ones", 16'hFFFF);
    test_word("zeros", 16'h0000);
    test_known_counts();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
